// File: rtl/subtractor_n_serial.sv
// ---------------------------------------------------------------------------
// subtractor_n_serial
//
// Digit-serial N-bit subtractor: computes (a - b - b_in) mod 2^N one K-bit
// digit per clock, least-significant digit first. A single borrow flop links
// consecutive digits. Operands arrive over a start valid/ready handshake.
// The result is presented over a done valid/ready handshake.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  operand request valid
//   start_ready  block can accept operands (IDLE only)
//   a, b         minuend / subtrahend, sampled on the start handshake
//   b_in         borrow-in, sampled on the start handshake
//   done_valid   result valid (DONE only)
//   done_ready   consumer accepts the result
//   diff         registered difference
//   b_out        borrow out of the MSB (a < b + b_in, unsigned)
//   overflow     signed overflow of the subtraction
//   zero         diff == 0
// ---------------------------------------------------------------------------
module subtractor_n_serial #(
   parameter int N = 32,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         b_in,
   output logic         done_valid,
   input  logic         done_ready,
   output logic [N-1:0] diff,
   output logic         b_out,
   output logic         overflow,
   output logic         zero
);

   localparam int D  = N / K;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [CW-1:0]   cnt;
   logic            borrow;
   logic [N-1:0]    a_sh;
   logic [N-1:0]    b_sh;
   logic [N-1:0]    res_sh;
   // Operand sign bits are kept aside: the shift registers lose them
   // before the overflow flag is formed on the last digit.
   logic            a_msb;
   logic            b_msb;

   logic [K:0]      sub;
   logic [N-1:0]    res_next;
   logic            last;

   // One digit of subtraction; bit K is the borrow out of this digit.
   assign sub  = {1'b0, a_sh[K-1:0]} - {1'b0, b_sh[K-1:0]} - {{K{1'b0}}, borrow};
   assign last = (cnt == CW'(D - 1));

   // New digit enters from the top, so after D digits the result is aligned.
   generate
      if (K == N) begin : g_single_digit
         assign res_next = sub[K-1:0];
      end else begin : g_multi_digit
         assign res_next = {sub[K-1:0], res_sh[N-1:K]};
      end
   endgenerate

   // -------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_valid) state_next = BUSY;
         BUSY: if (last)        state_next = DONE;
         DONE: if (done_ready)  state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // ----------------------------------------------------------------- outputs
   // Handshake outputs depend on the state register only.
   always_comb begin
      start_ready = (state == IDLE);
      done_valid  = (state == DONE);
   end

   // --------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         borrow   <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         diff     <= '0;
         b_out    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= b_in;
                  a_msb  <= a[N-1];
                  b_msb  <= b[N-1];
                  cnt    <= '0;
               end
            end
            BUSY: begin
               res_sh <= res_next;
               a_sh   <= a_sh >> K;
               b_sh   <= b_sh >> K;
               borrow <= sub[K];
               cnt    <= cnt + CW'(1);
               if (last) begin
                  diff     <= res_next;
                  b_out    <= sub[K];
                  overflow <= (a_msb ^ b_msb) & (a_msb ^ res_next[N-1]);
                  zero     <= (res_next == '0);
               end
            end
            default: begin
               // DONE: results held; nothing to compute.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subtractor_n_serial.sv
// ---------------------------------------------------------------------------
// tb_subtractor_n_serial
//
// Directed bench for subtractor_n_serial (N=32, K=8). Each scenario task
// drives its own stimulus and checks against hand-computed values.
// ---------------------------------------------------------------------------
module tb_subtractor_n_serial;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        b_in;
   logic        done_valid;
   logic        done_ready;
   logic [31:0] diff;
   logic        b_out;
   logic        overflow;
   logic        zero;

   int checks   = 0;
   int failures = 0;

   subtractor_n_serial #(.N(32), .K(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .b_in        (b_in),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .diff        (diff),
      .b_out       (b_out),
      .overflow    (overflow),
      .zero        (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request, wait for the accept edge, then count edges until
   // done_valid is seen (bounded). Returns the latency in cycles.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, output int lat);
      int guard;
      @(negedge clk);
      a = av; b = bv; b_in = bi; start_valid = 1'b1;
      guard = 0;
      while (!start_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      lat = 0;
      while (!done_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      $display("op a=%08h b=%08h b_in=%0d -> diff=%08h b_out=%0d ovf=%0d zero=%0d lat=%0d",
               av, bv, bi, diff, b_out, overflow, zero, lat);
   endtask

   task automatic release_done();
      @(negedge clk);
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      done_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
      a = '0; b = '0; b_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
         $display("FAIL reset_hs start_ready=%b done_valid=%b required 1/0", start_ready, done_valid);
         failures++;
      end
      checks++;
      if (diff !== 32'h0 || b_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
         $display("FAIL reset_out diff=%08h b_out=%b ovf=%b zero=%b required all 0",
                  diff, b_out, overflow, zero);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_basic();
      int lat;
      run_op(32'd5, 32'd3, 1'b0, lat);
      checks++;
      if (lat !== 4) begin
         $display("FAIL basic_latency got=%0d required=4", lat);
         failures++;
      end
      checks++;
      if (diff !== 32'h00000002 || b_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
         $display("FAIL basic_5_3 diff=%08h b_out=%b ovf=%b zero=%b required 00000002/0/0/0",
                  diff, b_out, overflow, zero);
         failures++;
      end
      checks++;
      if (start_ready !== 1'b0) begin
         $display("FAIL basic_ready_in_done got=%b required=0", start_ready);
         failures++;
      end
      release_done();
      checks++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
         $display("FAIL basic_back_idle start_ready=%b done_valid=%b required 1/0", start_ready, done_valid);
         failures++;
      end
   endtask

   task automatic test_borrow();
      int lat;
      run_op(32'd3, 32'd5, 1'b0, lat);
      checks++;
      if (diff !== 32'hFFFFFFFE || b_out !== 1'b1 || overflow !== 1'b0) begin
         $display("FAIL borrow_3_5 diff=%08h b_out=%b ovf=%b required FFFFFFFE/1/0", diff, b_out, overflow);
         failures++;
      end
      release_done();
      run_op(32'h00000100, 32'h00000001, 1'b0, lat);
      checks++;
      if (diff !== 32'h000000FF || b_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
         $display("FAIL borrow_digit_cross diff=%08h b_out=%b ovf=%b zero=%b required 000000FF/0/0/0",
                  diff, b_out, overflow, zero);
         failures++;
      end
      release_done();
   endtask

   task automatic test_overflow();
      int lat;
      run_op(32'h80000000, 32'h00000001, 1'b0, lat);
      checks++;
      if (diff !== 32'h7FFFFFFF || overflow !== 1'b1 || b_out !== 1'b0) begin
         $display("FAIL ovf_min_minus_1 diff=%08h ovf=%b b_out=%b required 7FFFFFFF/1/0", diff, overflow, b_out);
         failures++;
      end
      release_done();
      run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
      checks++;
      if (diff !== 32'h80000000 || overflow !== 1'b1 || b_out !== 1'b1) begin
         $display("FAIL ovf_max_minus_m1 diff=%08h ovf=%b b_out=%b required 80000000/1/1", diff, overflow, b_out);
         failures++;
      end
      release_done();
   endtask

   task automatic test_zero();
      int lat;
      run_op(32'h12345678, 32'h12345678, 1'b0, lat);
      checks++;
      if (diff !== 32'h0 || zero !== 1'b1 || b_out !== 1'b0 || overflow !== 1'b0) begin
         $display("FAIL zero_equal diff=%08h zero=%b b_out=%b ovf=%b required 00000000/1/0/0",
                  diff, zero, b_out, overflow);
         failures++;
      end
      release_done();
      run_op(32'h12345678, 32'h12345678, 1'b1, lat);
      checks++;
      if (diff !== 32'hFFFFFFFF || zero !== 1'b0 || b_out !== 1'b1 || overflow !== 1'b0) begin
         $display("FAIL zero_bin diff=%08h zero=%b b_out=%b ovf=%b required FFFFFFFF/0/1/0",
                  diff, zero, b_out, overflow);
         failures++;
      end
      release_done();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      run_op(32'd20, 32'd7, 1'b0, lat);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a = 32'hA5A5_0000 + i; b = 32'h0000_5A5A - i;
         b_in = i[0]; start_valid = ~start_valid;
         #1;
         if (diff !== 32'd13 || done_valid !== 1'b1 || start_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         $display("FAIL bp_stall bad_cycles=%0d diff=%08h done_valid=%b start_ready=%b required 0 / 0000000D/1/0",
                  bad, diff, done_valid, start_ready);
         failures++;
      end
      @(negedge clk);
      start_valid = 1'b0;
      release_done();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_valid !== 1'b0 || start_ready !== 1'b1 || diff !== 32'd13) begin
         $display("FAIL bp_no_second_op done_valid=%b start_ready=%b diff=%08h required 0/1/0000000D",
                  done_valid, start_ready, diff);
         failures++;
      end
      $display("backpressure held 6 cycles, diff=%08h", diff);
   endtask

   task automatic test_reset_mid_busy();
      int lat;
      @(negedge clk);
      a = 32'd100; b = 32'd1; b_in = 1'b0; start_valid = 1'b1;
      @(posedge clk);              // accept edge: first BUSY cycle follows
      #1;
      start_valid = 1'b0;
      @(posedge clk);              // second BUSY cycle begins
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0 || diff !== 32'h0 ||
          b_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
         $display("FAIL rst_mid_busy start_ready=%b done_valid=%b diff=%08h b_out=%b ovf=%b zero=%b required 1/0/0/0/0/0",
                  start_ready, done_valid, diff, b_out, overflow, zero);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd10, 32'd4, 1'b0, lat);
      checks++;
      if (lat !== 4 || diff !== 32'd6 || b_out !== 1'b0) begin
         $display("FAIL rst_recover lat=%0d diff=%08h b_out=%b required 4/00000006/0", lat, diff, b_out);
         failures++;
      end
      release_done();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow();
      test_overflow();
      test_zero();
      test_backpressure();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/subtractor_n_serial.md
# subtractor_n_serial

Multi-cycle N-bit subtractor computing a − b − b_in one K-bit digit per cycle, least-significant digit first, with a single borrow flop carried between digits. It is the arithmetic inverse of the N-bit adder in the ALU datapath. It is intended for area-constrained ALU/divider paths where a full-width subtract per cycle is not required. Operands enter and results leave over valid/ready handshakes.

## Interface
- N, 32: operand width in bits.
- K, 8: digit width processed per cycle; N must be a multiple of K, 1 ≤ K ≤ N.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_valid  input  1  operand request valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  minuend; sampled only on start handshake.
- b  input  N  subtrahend; sampled only on start handshake.
- b_in  input  1  borrow-in; sampled only on start handshake.
- done_valid  output  1  result valid; high only in DONE.
- done_ready  input  1  consumer accepts result.
- diff  output  N  registered difference, (a − b − b_in) mod 2^N.
- b_out  output  1  borrow out of the MSB; 1 iff a < b + b_in (unsigned).
- overflow  output  1  signed overflow: (a[N-1]^b[N-1]) & (a[N-1]^diff[N-1]).
- zero  output  1  diff == 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready, latch a, b into shift registers and b_in into the borrow flop, clear digit counter, then go to BUSY.
- BUSY, each cycle:
  - Compute low K bits of a_sh − b_sh − borrow as a (K+1)-bit result.
  - Shift the digit into the result register from the top.
  - Shift a_sh and b_sh right by K.
  - Update the borrow flop with the result bit K.
  - Increment the counter.
- BUSY ends after exactly N/K digit cycles:
  - On the last digit, load diff and compute b_out (final borrow), overflow and zero from the complete result.
  - Go to DONE.
- DONE: done_valid=1. diff, b_out, overflow and zero are stable. On done_valid&&done_ready, go to IDLE.
- diff, b_out, overflow and zero change only on the BUSY→DONE transition. They hold their values through IDLE until the next completion.
- Operand inputs are ignored outside the start handshake. Input changes during BUSY/DONE have no effect.
- start_valid while not in IDLE is ignored. The requester holds it until start_ready is seen.
- Counter width is clog2(N/K), minimum 1 bit. When K==N there is a single BUSY cycle.

## Timing
- Reset (rst_n low, any state, immediately and asynchronously):
  - state=IDLE; start_ready=1, done_valid=0.
  - diff=0, b_out=0, overflow=0, zero=0.
  - Counter, borrow and shift registers are cleared.
- Reset mid-BUSY or in DONE discards the operation. The first edge after rst_n rises can accept a new request.
- Latency: start accepted on edge T ⇒ done_valid high after edge T+N/K (4 cycles for N=32, K=8).
- Minimum initiation interval is N/K+2 cycles: BUSY, then DONE with done_ready=1, then IDLE.
- done_ready held low stalls indefinitely in DONE. Outputs stay stable and start_ready stays 0.
- start_ready and done_valid are decoded from the state register only, with no combinational path from inputs.

## Test plan
- N=32,K=8. a=5, b=3, b_in=0 → diff=0x00000002, b_out=0, overflow=0, zero=0. done_valid rises exactly 4 cycles after the accept edge.
- a=3, b=5, b_in=0 → diff=0xFFFFFFFE, b_out=1, overflow=0. Then a=0x00000100, b=1 → diff=0x000000FF: the borrow crosses a digit boundary.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, overflow=1, b_out=0. a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, overflow=1, b_out=1.
- a=b=0x12345678, b_in=0 → zero=1, b_out=0. Same operands with b_in=1 → diff=0xFFFFFFFF, zero=0, b_out=1.
- Backpressure: hold done_ready=0 for 6 cycles and toggle a/b/start_valid meanwhile. Required: outputs unchanged, start_ready=0, and no second operation starts until done_ready=1.
- Pull rst_n low in the 2nd BUSY cycle. Required: all outputs 0 and start_ready=1 immediately. The next request a=10, b=4 → diff=6 with the normal 4-cycle latency.
